// File: rtl/axis_skid_pkg.sv
// Shared types for the AXI-stream skid buffer.
package axis_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Full-handshake AXI-stream register slice: output register plus one skid register,
// with both the forward payload and the backward ready taken straight from flops.
module axis_skid_buffer
  import axis_skid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [DEST_WIDTH-1:0] in_dest_i,
  input  logic [USER_WIDTH-1:0] in_user_i,
  input  logic                  in_tlast_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [DEST_WIDTH-1:0] out_dest_o,
  output logic [USER_WIDTH-1:0] out_user_o,
  output logic                  out_tlast_o,
  input  logic                  out_ready_i
);

  localparam int unsigned PW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  skid_state_t   state_q, state_d;
  logic [PW-1:0] or_q, or_d;
  logic [PW-1:0] sr_q, sr_d;
  logic          out_valid_q;
  logic          in_ready_q;
  logic [PW-1:0] in_payload;
  logic          in_fire;
  logic          out_fire;

  assign in_payload = {in_tlast_i, in_user_i, in_dest_i, in_data_i};
  assign in_fire    = in_valid_i & in_ready_q;
  assign out_fire   = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sr_d    = sr_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          or_d    = in_payload;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          or_d = in_payload;
        end else if (in_fire) begin
          sr_d    = in_payload;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the downstream side can move
        if (out_fire) begin
          or_d    = sr_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      or_q        <= '0;
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      or_q        <= or_d;
      sr_q        <= sr_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != FULL);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign {out_tlast_o, out_user_o, out_dest_o, out_data_o} = or_q;

endmodule

// File: tb/tb_axis_skid_buffer.sv
// Directed and randomised checks for axis_skid_buffer.
module tb_axis_skid_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 3 * DW + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_dest = '0;
  logic [DW-1:0] in_user = '0;
  logic          in_tlast = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [DW-1:0] out_dest;
  logic [DW-1:0] out_user;
  logic          out_tlast;
  logic          out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  axis_skid_buffer #(
    .DATA_WIDTH(DW),
    .DEST_WIDTH(DW),
    .USER_WIDTH(DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_dest_i   (in_dest),
    .in_user_i   (in_user),
    .in_tlast_i  (in_tlast),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_dest_o  (out_dest),
    .out_user_o  (out_user),
    .out_tlast_o (out_tlast),
    .out_ready_i (out_ready)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic last);
    in_valid = v;
    in_data  = d;
    in_dest  = d + 32'h100;
    in_user  = ~d;
    in_tlast = last;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'hDEAD, 1'b1);
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tlast !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%0b data=%h tlast=%0b ready=%0b, want 0/0/0/0",
               out_valid, out_data, out_tlast, in_ready);
    end
    drive(1'b0, '0, 1'b0);
    reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%0b valid=%0b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(i + 1), (i == 7));
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== DW'(i + 1) ||
          out_dest !== DW'(i + 1) + 32'h100 || out_user !== ~DW'(i + 1) ||
          out_tlast !== (i == 7)) begin
        failures++;
        $display("FAIL stream_beat%0d: ready=%0b valid=%0b data=%h tlast=%0b, want 1/1/%h/%0b",
                 i, in_ready, out_valid, out_data, out_tlast, i + 1, (i == 7));
      end
    end
    drive(1'b0, '0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stream_drain: valid=%0b ready=%0b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(1'b1, 32'hA0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL skid_a0: valid=%0b data=%h ready=%0b, want 1/a0/1", out_valid, out_data, in_ready);
    end
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL skid_full: valid=%0b data=%h ready=%0b, want 1/a0/0", out_valid, out_data, in_ready);
    end
    drive(1'b1, 32'hA2, 1'b1);
    step();
    checks++;
    if (out_data !== 32'hA0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL skid_hold: data=%h ready=%0b, want a0/0", out_data, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA1 || out_tlast !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL skid_a1: valid=%0b data=%h tlast=%0b ready=%0b, want 1/a1/0/1",
               out_valid, out_data, out_tlast, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA2 || out_tlast !== 1'b1) begin
      failures++;
      $display("FAIL skid_a2: valid=%0b data=%h tlast=%0b, want 1/a2/1", out_valid, out_data, out_tlast);
    end
    drive(1'b0, '0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL skid_nodup: valid=%0b data=%h, want valid 0", out_valid, out_data);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'hB0, 1'b1);
    step();
    drive(1'b1, 32'hB1, 1'b0);
    step();
    drive(1'b1, 32'hB2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hB0 || out_dest !== 32'h1B0 ||
          out_user !== ~32'hB0 || out_tlast !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_cycle%0d: valid=%0b data=%h dest=%h user=%h tlast=%0b ready=%0b, want 1/b0/1b0/%h/1/0",
                 i, out_valid, out_data, out_dest, out_user, out_tlast, in_ready, ~32'hB0);
      end
    end
    drive(1'b0, '0, 1'b0);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hB1 || out_tlast !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: valid=%0b data=%h, want 1/b1", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_empty: valid=%0b ready=%0b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] sb[$];
    logic [PW-1:0] exp_p;
    logic [PW-1:0] got_p;
    logic          in_fire, out_fire, both;
    int            sent = 0;
    int            rcvd = 0;
    int            cyc = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = $urandom();
      in_dest   = DW'(sent);
      in_user   = ~DW'(sent);
      in_tlast  = (sent % 7 == 6);
      out_ready = ($urandom_range(0, 1) == 1);
      in_fire   = in_valid & in_ready;
      out_fire  = out_valid & out_ready;
      both      = in_fire & out_fire;
      if (out_fire) begin
        got_p = {out_tlast, out_user, out_dest, out_data};
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious: got %h with empty scoreboard", got_p);
        end else begin
          exp_p = sb.pop_front();
          if (got_p !== exp_p) begin
            failures++;
            $display("FAIL rand_beat%0d: got %h, want %h", rcvd, got_p, exp_p);
          end
        end
        rcvd++;
      end
      if (in_fire) begin
        sb.push_back({in_tlast, in_user, in_dest, in_data});
        sent++;
      end
      step();
      cyc++;
      if (both) begin
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL rand_throughput: ready=%0b valid=%0b after dual fire, want 1/1", in_ready, out_valid);
        end
      end
    end
    checks++;
    if (rcvd < 1000 || sb.size() != 0) begin
      failures++;
      $display("FAIL rand_complete: received=%0d pending=%0d, want 1000/0", rcvd, sb.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_idle: valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 1'b0);
    step();
    drive(1'b1, 32'h66, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    reset = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: valid=%0b data=%h ready=%0b, want 0/0/0", out_valid, out_data, in_ready);
    end
    reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release: ready=%0b valid=%0b, want 1/0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h77, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77) begin
      failures++;
      $display("FAIL midreset_new: valid=%0b data=%h, want 1/77", out_valid, out_data);
    end
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_replay%0d: valid=%0b data=%h, want valid 0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    drive(1'b1, 32'hBEEF, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hBEEF || out_tlast !== 1'b1) begin
      failures++;
      $display("FAIL drain_beat: valid=%0b data=%h tlast=%0b, want 1/beef/1", out_valid, out_data, out_tlast);
    end
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL drain_empty%0d: valid=%0b ready=%0b, want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_random();
    test_reset_mid();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
